// File: rtl/elevator_dispatcher.sv
// Hall-call dispatcher for a three-car elevator bank: latches hall-call presses,
// scans them round-robin and sends the nearest free car with a one-cycle go pulse.
module elevator_dispatcher #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    pos1,
  input  logic [FLOOR_W-1:0]    pos2,
  input  logic [FLOOR_W-1:0]    pos3,
  input  logic                  busy1,
  input  logic                  busy2,
  input  logic                  busy3,
  output logic [FLOOR_W-1:0]    floor1,
  output logic [FLOOR_W-1:0]    floor2,
  output logic [FLOOR_W-1:0]    floor3,
  output logic                  go1,
  output logic                  go2,
  output logic                  go3,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, SCAN, PICK, ISSUE} state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_FLOORS-1:0] r_call_req_d;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [FLOOR_W-1:0]    r_scan_ptr;
  logic [FLOOR_W-1:0]    r_sel_floor;
  logic [FLOOR_W-1:0]    r_floor [3];
  logic [2:0]            r_go;
  logic [2:0]            r_reserved;

  logic [FLOOR_W-1:0]    w_pos [3];
  logic [2:0]            w_busy;
  logic [NUM_FLOORS-1:0] w_rise;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [FLOOR_W-1:0]    w_scan_idx;
  logic [FLOOR_W-1:0]    w_scan_floor;
  logic                  w_scan_found;
  logic [FLOOR_W-1:0]    w_dist [3];
  logic [2:0]            w_avail;
  logic [FLOOR_W-1:0]    w_best;
  logic [1:0]            w_sel_car;
  logic                  w_any_avail;
  logic                  w_issue;
  logic [FLOOR_W-1:0]    w_ptr_nxt;

  assign w_pos[0] = pos1;
  assign w_pos[1] = pos2;
  assign w_pos[2] = pos3;
  assign w_busy   = {busy3, busy2, busy1};

  assign w_rise    = call_req & ~r_call_req_d;
  assign w_issue   = (r_state == PICK) && w_any_avail;
  assign w_clr     = w_issue ? (NUM_FLOORS'(1) << r_sel_floor) : '0;
  assign w_ptr_nxt = FLOOR_W'((int'(r_sel_floor) + 1) % NUM_FLOORS);

  // First pending floor at or above the scan pointer, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    w_scan_found = 1'b0;
    w_scan_floor = '0;
    w_scan_idx   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_scan_idx = FLOOR_W'((int'(r_scan_ptr) + i) % NUM_FLOORS);
      if (!w_scan_found && r_pending[w_scan_idx]) begin
        w_scan_found = 1'b1;
        w_scan_floor = w_scan_idx;
      end
    end
  end

  // Nearest available car; strict '<' keeps ties on the lowest car index.
  always_comb begin
    w_any_avail = 1'b0;
    w_best      = '0;
    w_sel_car   = 2'd0;
    w_avail     = '0;
    for (int c = 0; c < 3; c++) begin
      w_avail[c] = !w_busy[c] && !r_reserved[c];
      w_dist[c]  = (w_pos[c] >= r_sel_floor) ? (w_pos[c] - r_sel_floor)
                                             : (r_sel_floor - w_pos[c]);
      if (w_avail[c] && (!w_any_avail || (w_dist[c] < w_best))) begin
        w_any_avail = 1'b1;
        w_best      = w_dist[c];
        w_sel_car   = 2'(c);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (|r_pending) w_state_nxt = SCAN;
      SCAN:    w_state_nxt = PICK;
      PICK:    w_state_nxt = w_any_avail ? ISSUE : IDLE;
      ISSUE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // A button held through reset is not a fresh press.
      r_call_req_d <= '1;
      r_pending    <= '0;
      r_scan_ptr   <= '0;
      r_sel_floor  <= '0;
      r_go         <= '0;
      r_reserved   <= '0;
      // NOTE: the target array is only three entries and drives outputs, so it
      // is reset element by element rather than left uninitialised.
      for (int c = 0; c < 3; c++) r_floor[c] <= '0;
    end else begin
      r_call_req_d <= call_req;
      r_pending    <= (r_pending & ~w_clr) | w_rise;
      if (r_state == SCAN) r_sel_floor <= w_scan_floor;
      if (w_issue)         r_scan_ptr  <= w_ptr_nxt;
      for (int c = 0; c < 3; c++) begin
        r_go[c] <= w_issue && (w_sel_car == 2'(c));
        if (w_issue && (w_sel_car == 2'(c))) begin
          r_floor[c]    <= r_sel_floor;
          r_reserved[c] <= 1'b1;
        end else if (!w_busy[c] && (w_pos[c] == r_floor[c])) begin
          r_reserved[c] <= 1'b0;
        end
      end
    end
  end

  assign floor1  = r_floor[0];
  assign floor2  = r_floor[1];
  assign floor3  = r_floor[2];
  assign go1     = r_go[0];
  assign go2     = r_go[1];
  assign go3     = r_go[2];
  assign pending = r_pending;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher: a vector table of single dispatches
// plus hand-written sequences for reset, reservation, round-robin and busy cars.
module tb_elevator_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] call_req;
  logic [2:0] pos1, pos2, pos3;
  logic       busy1, busy2, busy3;
  logic [2:0] floor1, floor2, floor3;
  logic       go1, go2, go3;
  logic [7:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  elevator_dispatcher #(.NUM_FLOORS(8), .FLOOR_W(3)) dut (
    .clk(clk), .rst(rst), .call_req(call_req),
    .pos1(pos1), .pos2(pos2), .pos3(pos3),
    .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .floor1(floor1), .floor2(floor2), .floor3(floor3),
    .go1(go1), .go2(go2), .go3(go3),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] p1, p2, p3;
    logic [2:0] busy;     // bit 0 = car 1
    int         floor;
    logic [2:0] exp_go;   // bit 0 = car 1; 0 = no car available
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [2:0] gos();
    return {go3, go2, go1};
  endfunction

  task automatic set_cars(input logic [2:0] p1, input logic [2:0] p2, input logic [2:0] p3,
                          input logic [2:0] busy);
    pos1 = p1; pos2 = p2; pos3 = p3;
    {busy3, busy2, busy1} = busy;
  endtask

  // Reset, then leave one edge with buttons low so the next press is a rising edge.
  task automatic do_reset();
    call_req = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_go(input int max_cyc, output logic [2:0] g, output int n);
    n = 0;
    g = '0;
    while (n < max_cyc && g == 3'b000) begin
      tick();
      n++;
      g = gos();
    end
  endtask

  initial begin
    logic [2:0] g;
    int         n;
    logic [7:0] oh;
    logic       saw_go;

    vecs[0] = '{3'd0, 3'd5, 3'd7, 3'b000, 4, 3'b010};
    vecs[1] = '{3'd2, 3'd6, 3'd7, 3'b000, 4, 3'b001};
    vecs[2] = '{3'd3, 3'd3, 3'd3, 3'b000, 3, 3'b001};
    vecs[3] = '{3'd0, 3'd0, 3'd7, 3'b001, 7, 3'b100};
    vecs[4] = '{3'd7, 3'd0, 3'd4, 3'b000, 0, 3'b010};
    vecs[5] = '{3'd1, 3'd6, 3'd2, 3'b010, 5, 3'b100};
    vecs[6] = '{3'd4, 3'd4, 3'd4, 3'b111, 3, 3'b000};
    vecs[7] = '{3'd4, 3'd4, 3'd4, 3'b011, 0, 3'b100};

    // Reset with every button held: outputs clear, and release creates no call.
    set_cars(3'd0, 3'd0, 3'd0, 3'b000);
    call_req = 8'hFF;
    rst = 1'b0;
    tick();
    check("rst_go", 32'(gos()), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_floors", 32'({floor3, floor2, floor1}), 0);
    rst = 1'b1;
    wait_go(6, g, n);
    check("held_after_rst_go", 32'(g), 0);
    check("held_after_rst_pending", 32'(pending), 0);

    // Single-dispatch table: go must appear exactly on the third edge after capture.
    foreach (vecs[i]) begin
      set_cars(vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].busy);
      do_reset();
      oh = 8'h01 << vecs[i].floor;
      call_req = oh;
      tick();
      check($sformatf("v%0d_pending_set", i), 32'(pending), 32'(oh));
      saw_go = 1'b0;
      for (int k = 0; k < 2; k++) begin
        tick();
        if (gos() != 3'b000) saw_go = 1'b1;
      end
      check($sformatf("v%0d_early_go", i), 32'(saw_go), 0);
      tick();
      check($sformatf("v%0d_go", i), 32'(gos()), 32'(vecs[i].exp_go));
      check($sformatf("v%0d_floors", i), 32'({floor3, floor2, floor1}),
            32'({vecs[i].exp_go[2] ? 3'(vecs[i].floor) : 3'd0,
                 vecs[i].exp_go[1] ? 3'(vecs[i].floor) : 3'd0,
                 vecs[i].exp_go[0] ? 3'(vecs[i].floor) : 3'd0}));
      call_req = '0;
      tick();
      check($sformatf("v%0d_go_one_cycle", i), 32'(gos()), 0);
      check($sformatf("v%0d_pending_after", i), 32'(pending),
            (vecs[i].exp_go == 3'b000) ? 32'(oh) : 0);
    end

    // All cars busy: call waits; freeing car 3 at floor 1 sends it to floor 3.
    set_cars(3'd0, 3'd0, 3'd0, 3'b111);
    do_reset();
    call_req = 8'h08;
    wait_go(8, g, n);
    check("busy_no_go", 32'(g), 0);
    check("busy_pending_held", 32'(pending), 32'h08);
    set_cars(3'd0, 3'd0, 3'd1, 3'b011);
    wait_go(6, g, n);
    check("freed_go3", 32'(g), 32'b100);
    check("freed_latency", 32'(n <= 4), 1);
    check("freed_floor3", 32'(floor3), 3);
    call_req = '0;

    // Reservation: car 1 heading to 6 is skipped until it arrives there.
    set_cars(3'd0, 3'd3, 3'd7, 3'b110);
    do_reset();
    call_req = 8'h40;
    wait_go(6, g, n);
    check("resv_first_go1", 32'(g), 32'b001);
    check("resv_floor1", 32'(floor1), 6);
    call_req = '0;
    set_cars(3'd0, 3'd3, 3'd7, 3'b000);
    tick();
    call_req = 8'h02;
    wait_go(8, g, n);
    check("resv_skip_car1", 32'(g), 32'b010);
    check("resv_floor2", 32'(floor2), 1);
    call_req = '0;
    set_cars(3'd6, 3'd3, 3'd7, 3'b000);
    tick();
    call_req = 8'h20;
    wait_go(8, g, n);
    check("resv_cleared_go1", 32'(g), 32'b001);
    check("resv_floor1_new", 32'(floor1), 5);
    call_req = '0;

    // Round-robin: after floor 2 is served the pointer sits at 3, so 5 goes before 2.
    set_cars(3'd2, 3'd5, 3'd0, 3'b000);
    do_reset();
    call_req = 8'h04;
    wait_go(6, g, n);
    check("rr_prime_go1", 32'(g), 32'b001);
    call_req = '0;
    tick(); tick(); tick();
    call_req = 8'h24;
    wait_go(8, g, n);
    check("rr_first_go2", 32'(g), 32'b010);
    check("rr_first_floor2", 32'(floor2), 5);
    check("rr_pending_left", 32'(pending), 32'h04);
    wait_go(8, g, n);
    check("rr_second_go1", 32'(g), 32'b001);
    check("rr_spacing", 32'(n), 4);
    check("rr_second_floor1", 32'(floor1), 2);
    call_req = '0;

    // Reset while the call sits in PICK: the call is lost and nothing is issued.
    set_cars(3'd0, 3'd0, 3'd0, 3'b000);
    do_reset();
    call_req = 8'h80;
    tick();
    check("mid_pending_set", 32'(pending), 32'h80);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("mid_rst_go", 32'(gos()), 0);
    check("mid_rst_pending", 32'(pending), 0);
    tick();
    rst = 1'b1;
    wait_go(6, g, n);
    check("mid_after_go", 32'(g), 0);
    check("mid_after_pending", 32'(pending), 0);
    check("mid_after_floors", 32'({floor3, floor2, floor1}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
